// File: rtl/pulse_pos_tx.sv
// Pulse-position transmitter: serializes a frame MSB first, one bit per BIT_PERIOD clocks.
// Optional build macro SYNC_INSERT_EN forces the receiver sync fields (bits 62:58, 36:32) at capture.
module pulse_pos_tx #(
  parameter int FRAME_BITS  = 64,
  parameter int BIT_PERIOD  = 10000,
  parameter int PULSE_POS   = 2500,
  parameter int PULSE_WIDTH = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FRAME_BITS-1:0]         din,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          tx_abort,
  output logic                          rfout,
  output logic                          bit_strobe,
  output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
  output logic                          busy,
  output logic                          tx_done
);

  // state  | meaning
  // IDLE   | waiting for a frame, tx_ready high
  // TX     | serializing, period counter running
  // GAP    | enforced idle after a frame, rfout low
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TX   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IDX_W = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] PULSE_LO  = CNT_W'(PULSE_POS);
  localparam logic [CNT_W-1:0] PULSE_HI  = CNT_W'(PULSE_POS + PULSE_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SYNC_INSERT_EN
  localparam logic [FRAME_BITS-1:0] SYNC_MASK = FRAME_BITS'(64'h7C00_001F_0000_0000);
`else
  localparam logic [FRAME_BITS-1:0] SYNC_MASK = '0;
`endif

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  rfout_q, rfout_d;
  logic                  strobe_q, strobe_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d  = S_TX;
          cnt_d    = '0;
          idx_d    = IDX_FIRST;
          shift_d  = din | SYNC_MASK;
          strobe_d = 1'b1;
        end
      end
      S_TX: begin
        if (tx_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q << 1;
          if (idx_q == '0) begin
            done_d = 1'b1;
            gap_d  = GAP_LOAD;
            if (GAP_CYCLES > 0) state_d = S_GAP;
            else                state_d = S_IDLE;
          end else begin
            idx_d    = idx_q - 1'b1;
            strobe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (tx_abort || gap_q == '0) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        gap_d   = '0;
        idx_d   = '0;
        shift_d = '0;
      end
    endcase
    // Decode the pulse from next-state values so rfout comes straight off a flop.
    rfout_d = (state_d == S_TX) && (cnt_d >= PULSE_LO) && (cnt_d <= PULSE_HI)
              && shift_d[FRAME_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      rfout_q  <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      rfout_q  <= rfout_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rfout      = rfout_q;
  assign bit_strobe = strobe_q;
  assign bit_idx    = idx_q;
  assign tx_done    = done_q;

endmodule
